// File: rtl/divide_arb_pkg.sv
// -----------------------------------------------------------------------------
// divide_arb_pkg
//   Shared definitions for the divider arbiter:
//     - arb_state_e : controller states (IDLE, ISSUE, WAIT, CLEAR, RESP)
//     - sat_pos/neg : saturation constants for a signed word of width w,
//                     used when a zero divisor bypasses the divider
//     - id_width    : width of a requester index for n requesters
// -----------------------------------------------------------------------------
package divide_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest positive value of a w-bit signed word, zero-extended to 64 bits.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed word (only the sign bit set).
  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The search starts at the
//   requester after last_grant and wraps around; the first asserted request
//   wins. The owner of last_grant is the parent.
//   Ports:
//     last_grant  in   ID_W   index granted most recently
//     req         in   N_REQ  request vector
//     grant       out  N_REQ  one-hot grant (all zero when req is zero)
//     grant_idx   out  ID_W   index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
  import divide_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [ID_W-1:0]  last_grant,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((int'(last_grant) + off) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/divide_arbiter.sv
// -----------------------------------------------------------------------------
// divide_arbiter
//   Shares one iterative signed fixed-point divider among N_REQ requesters.
//   One request is in flight at a time; requesters are served round-robin.
//   The controller walks IDLE -> ISSUE -> WAIT -> CLEAR -> RESP -> IDLE,
//   pulsing the divider start and clear strobes and returning the quotient
//   with the requester index on a valid/ready response channel. A divide
//   that takes TIMEOUT cycles in WAIT is abandoned with rsp_err set.
//
//   Optional build macro DIVIDE_ARB_ZERO_BYPASS_EN: a granted request with a
//   zero divisor skips the divider and answers directly with a saturated
//   quotient (sign taken from the dividend) and rsp_err clear.
//
//   Ports:
//     clock          in   1              rising-edge clock
//     reset          in   1              asynchronous, active-low
//     req_valid      in   N_REQ          per-requester request valid
//     req_ready      out  N_REQ          one-hot accept, IDLE only
//     req_dividend   in   N_REQ*D_WIDTH  packed, slice i = requester i
//     req_divisor    in   N_REQ*D_WIDTH  packed, slice i = requester i
//     div_valid_in   out  1              divider start pulse
//     div_dividend   out  D_WIDTH        latched operand
//     div_divisor    out  D_WIDTH        latched operand
//     div_valid_out  in   1              divider done (level until cleared)
//     div_quotient   in   D_WIDTH        divider result
//     div_clear      out  1              returns the divider to idle
//     rsp_valid      out  1              response valid
//     rsp_ready      in   1              response accepted
//     rsp_id         out  ID_W           requester being answered
//     rsp_quotient   out  D_WIDTH        result
//     rsp_err        out  1              divide timed out
//     busy           out  1              controller not in IDLE
// -----------------------------------------------------------------------------
module divide_arbiter
  import divide_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 32,
  parameter int Q_BITS  = 10,
  parameter int TIMEOUT = 255,
  parameter int ID_W    = id_width(N_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*D_WIDTH-1:0] req_dividend,
  input  logic [N_REQ*D_WIDTH-1:0] req_divisor,
  output logic                     div_valid_in,
  output logic [D_WIDTH-1:0]       div_dividend,
  output logic [D_WIDTH-1:0]       div_divisor,
  input  logic                     div_valid_out,
  input  logic [D_WIDTH-1:0]       div_quotient,
  output logic                     div_clear,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [D_WIDTH-1:0]       rsp_quotient,
  output logic                     rsp_err,
  output logic                     busy
);

  // The fractional-bit count only matters for interpreting the saturation
  // constants; reject configurations with no integer bits at all.
  if (Q_BITS >= D_WIDTH) begin : g_bad_q_bits
    $error("divide_arbiter: Q_BITS must be smaller than D_WIDTH");
  end

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

`ifdef DIVIDE_ARB_ZERO_BYPASS_EN
  localparam logic [D_WIDTH-1:0] SAT_POS = D_WIDTH'(sat_pos(D_WIDTH));
  localparam logic [D_WIDTH-1:0] SAT_NEG = D_WIDTH'(sat_neg(D_WIDTH));
`endif

  arb_state_e                 state_q, state_d;
  logic [ID_W-1:0]            last_grant_q, last_grant_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic signed [D_WIDTH-1:0]  dividend_q, dividend_d;
  logic signed [D_WIDTH-1:0]  divisor_q, divisor_d;
  logic signed [D_WIDTH-1:0]  quot_q, quot_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [N_REQ-1:0]           grant_oh;
  logic [ID_W-1:0]            grant_idx;
  logic [D_WIDTH-1:0]         dvd_arr [N_REQ];
  logic [D_WIDTH-1:0]         dvs_arr [N_REQ];
  logic signed [D_WIDTH-1:0]  sel_dividend;
  logic signed [D_WIDTH-1:0]  sel_divisor;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign dvd_arr[i] = req_dividend[i*D_WIDTH +: D_WIDTH];
    assign dvs_arr[i] = req_divisor[i*D_WIDTH +: D_WIDTH];
  end

  assign sel_dividend = dvd_arr[grant_idx];
  assign sel_divisor  = dvs_arr[grant_idx];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .last_grant (last_grant_q),
    .req        (req_valid),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant_oh) begin
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          dividend_d   = sel_dividend;
          divisor_d    = sel_divisor;
`ifdef DIVIDE_ARB_ZERO_BYPASS_EN
          if (sel_divisor == '0) begin
            quot_d  = sel_dividend[D_WIDTH-1] ? SAT_NEG : SAT_POS;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done that arrives on the last allowed cycle still wins over
        // the timeout.
        if (div_valid_out) begin
          quot_d  = div_quotient;
          err_d   = 1'b0;
          state_d = ST_CLEAR;
        end else if (cnt_q == TO_LAST) begin
          quot_d  = '0;
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // req_ready is combinational from req_valid; gating it with reset keeps
  // every output at zero while reset is held.
  assign req_ready    = (state_q == ST_IDLE && reset) ? grant_oh : '0;
  assign div_valid_in = (state_q == ST_ISSUE);
  assign div_clear    = (state_q == ST_CLEAR);
  assign rsp_valid    = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign rsp_id       = id_q;
  assign rsp_quotient = quot_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_divide_arbiter.sv
`timescale 1ns/1ps
module tb_divide_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int IDW     = 2;
  localparam int TO      = 100;
  localparam int DIV_LAT = 64;
`ifdef DIVIDE_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic           div_valid_in;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_valid_out = 1'b0;
  logic [W-1:0]   div_quotient = '0;
  logic           div_clear;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic           rsp_err;
  logic           busy;

  always #5 clock = ~clock;

  divide_arbiter #(
    .N_REQ   (N),
    .D_WIDTH (W),
    .Q_BITS  (10),
    .TIMEOUT (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_valid_in  (div_valid_in),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_valid_out (div_valid_out),
    .div_quotient  (div_quotient),
    .div_clear     (div_clear),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference divide: round-half-away-from-zero of (a<<10)/b; 0 for b==0.
  function automatic logic [W-1:0] model_div(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
    longint n, d, an, ad, q;
    logic [63:0] qv;
    if (b == 0) return '0;
    n  = longint'(a) * 1024;
    d  = longint'(b);
    an = (n < 0) ? -n : n;
    ad = (d < 0) ? -d : d;
    q  = (2 * an + ad) / (2 * ad);
    if ((n < 0) != (d < 0)) q = -q;
    qv = q;
    return qv[W-1:0];
  endfunction

  // ---------------- divider stub ----------------
  bit  hang = 1'b0;
  bit  dv_busy = 1'b0;
  int  dv_cnt = 0;
  initial begin : divider_stub
    logic st, cl;
    logic [W-1:0] a, b;
    forever begin
      @(negedge clock);
      st = div_valid_in;
      cl = div_clear;
      a  = div_dividend;
      b  = div_divisor;
      @(posedge clock);
      #1;
      if (!reset) begin
        dv_busy = 1'b0; div_valid_out = 1'b0; div_quotient = '0;
      end else if (cl) begin
        dv_busy = 1'b0; div_valid_out = 1'b0;
      end else if (st) begin
        dv_busy = 1'b1; dv_cnt = 0; div_valid_out = 1'b0;
        div_quotient = model_div(a, b);
      end else if (dv_busy && !div_valid_out && !hang) begin
        dv_cnt++;
        if (dv_cnt == DIV_LAT - 1) div_valid_out = 1'b1;
      end
    end
  end

  // ---------------- transaction-level model + compare ----------------
  int           cyc = 0;
  bit           inflight = 1'b0;
  int           last_g = N - 1;
  logic [N-1:0] acc_mask = '0;
  int           cur_id, cur_rise, n_issue, n_clear;
  logic [W-1:0] cur_a, cur_b, cur_q;
  bit           cur_err, cur_byp;
  logic [W-1:0] last_q;
  int           last_id;
  bit           last_err;
  int           rsp_log[$];

  initial begin : compare
    logic [N-1:0] exp_ready;
    int           eg;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        inflight = 1'b0;
        last_g   = N - 1;
        acc_mask = '0;
        continue;
      end
      exp_ready = '0;
      eg = -1;
      if (!inflight) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last_g + k) % N;
          if (eg < 0 && req_valid[j]) begin
            eg = j;
            exp_ready[j] = 1'b1;
          end
        end
      end
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, inflight);
      acc_mask = req_ready;
      if (inflight) begin
        if (div_valid_in) begin
          n_issue++;
          chk("issue_dividend", div_dividend, cur_a);
          chk("issue_divisor", div_divisor, cur_b);
        end
        if (div_clear) begin
          n_clear++;
          chk("clear_dividend", div_dividend, cur_a);
          chk("clear_divisor", div_divisor, cur_b);
        end
        chk("rsp_valid", rsp_valid, (cyc >= cur_rise));
        if (rsp_valid) begin
          chk("rsp_id", rsp_id, cur_id);
          chk("rsp_quotient", rsp_quotient, cur_q);
          chk("rsp_err", rsp_err, cur_err);
          chk("issue_pulses", n_issue, cur_byp ? 0 : 1);
          chk("clear_pulses", n_clear, cur_byp ? 0 : 1);
          if (rsp_ready) begin
            last_q   = rsp_quotient;
            last_id  = rsp_id;
            last_err = rsp_err;
            rsp_log.push_back(int'(rsp_id));
            inflight = 1'b0;
          end
        end
      end else begin
        chk("idle_strobes", {div_valid_in, div_clear, rsp_valid}, 0);
      end
      if (eg >= 0) begin
        inflight = 1'b1;
        last_g   = eg;
        cur_id   = eg;
        cur_a    = req_dividend[eg*W +: W];
        cur_b    = req_divisor[eg*W +: W];
        cur_byp  = BYPASS && (cur_b == '0);
        n_issue  = 0;
        n_clear  = 0;
        if (cur_byp) begin
          cur_q    = cur_a[W-1] ? 32'h8000_0000 : 32'h7fff_ffff;
          cur_err  = 1'b0;
          cur_rise = cyc + 1;
        end else if (hang) begin
          cur_q    = '0;
          cur_err  = 1'b1;
          cur_rise = cyc + TO + 3;
        end else begin
          cur_q    = model_div(cur_a, cur_b);
          cur_err  = 1'b0;
          cur_rise = cyc + DIV_LAT + 3;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic wait_accepts(input logic [N-1:0] mask, input int budget);
    logic [N-1:0] got;
    got = '0;
    for (int n = 0; n < budget && got != mask; n++) begin
      tick();
      got |= acc_mask & mask;
      req_valid &= ~acc_mask;
    end
    chk("accepted_mask", got, mask);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && inflight; n++) tick();
    chk("idle_within_budget", inflight, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_div_valid_in"}, div_valid_in, 0);
    chk({tag, "_div_clear"}, div_clear, 0);
    chk({tag, "_div_dividend"}, div_dividend, 0);
    chk({tag, "_div_divisor"}, div_divisor, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_quotient"}, rsp_quotient, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk_zero_outputs("reset");
    repeat (2) tick();
    reset = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_a();
    int v;
    v = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 200000));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_b();
    int v;
    v = int'($urandom_range(1, 3000));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    // Model pins.
    chk("model_30_4", longint'($signed(model_div(30, 4))), 7680);
    chk("model_m5_2", longint'($signed(model_div(-5, 2))), -2560);
    chk("model_1_3", longint'($signed(model_div(1, 3))), 341);
    chk("model_2_3", longint'($signed(model_div(2, 3))), 683);

    #1;
    chk_zero_outputs("reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Single request, rsp_ready already high.
    rsp_ready = 1'b1;
    set_req(2, 30, 4);
    wait_accepts(4'b0100, 20);
    wait_idle(200);
    chk("r2_id", last_id, 2);
    chk("r2_quot", last_q, 7680);
    chk("r2_err", last_err, 0);

    // All four requesters at once, fresh round-robin pointer.
    apply_reset();
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_req(i, (i + 1) * 100, 7);
    wait_accepts(4'hF, 500);
    wait_idle(200);
    chk("rr_count", rsp_log.size(), 4);
    for (int i = 0; i < N && i < rsp_log.size(); i++) chk("rr_order", rsp_log[i], i);

    // Response back-pressure for 10 cycles while another requester waits.
    rsp_ready = 1'b0;
    set_req(1, 1000, 3);
    wait_accepts(4'b0010, 20);
    for (int n = 0; n < 200 && !rsp_valid; n++) tick();
    chk("bp_rsp_seen", rsp_valid, 1);
    set_req(0, -777, 9);
    repeat (10) tick();
    chk("bp_still_busy", inflight, 1);
    rsp_ready = 1'b1;
    wait_idle(20);
    chk("bp_quot", last_q, model_div(1000, 3));
    wait_accepts(4'b0001, 20);
    wait_idle(200);
    chk("after_bp_id", last_id, 0);

    // Zero divisor.
    set_req(3, -5, 0);
    wait_accepts(4'b1000, 20);
    wait_idle(200);
    chk("zero_div_quot", last_q, BYPASS ? 32'h8000_0000 : 32'h0);
    chk("zero_div_err", last_err, 0);

    // Divider never finishes -> timeout, then a normal request.
    hang = 1'b1;
    set_req(3, 50, 5);
    wait_accepts(4'b1000, 20);
    wait_idle(TO + 20);
    chk("timeout_err", last_err, 1);
    chk("timeout_quot", last_q, 0);
    hang = 1'b0;
    set_req(0, 9, 2);
    wait_accepts(4'b0001, 20);
    wait_idle(200);
    chk("post_to_quot", last_q, 4608);
    chk("post_to_err", last_err, 0);

    // Reset while waiting on the divider.
    set_req(1, 77, 3);
    wait_accepts(4'b0010, 20);
    repeat (5) tick();
    req_valid = 4'b1001;
    reset = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    repeat (2) tick();
    rsp_log.delete();
    set_req(3, 60, 4);
    set_req(0, 40, 8);
    reset = 1'b1;
    wait_accepts(4'b1001, 300);
    wait_idle(200);
    chk("post_reset_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      chk("post_reset_first", rsp_log[0], 0);
      chk("post_reset_second", rsp_log[1], 3);
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_a(), rand_b());
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divide_arbiter.md
Name: divide_arbiter

Overview:
- Shares one iterative fixed-point divider among N_REQ requesters in the ray tracer datapath, e.g. the intersection and normalisation units.
- Accepts one request at a time using round-robin arbitration.
- Sequences the divider's start/done/clear handshake.
- Returns the quotient with the requester ID over a valid/ready response channel.

Parameters:
- N_REQ, 4, number of requesters.
- D_WIDTH, 32, operand/quotient width (signed).
- Q_BITS, 10, fractional bits; used only for the saturation constants.
- TIMEOUT, 255, maximum cycles spent in WAIT before the divide is aborted.
- ID_W, $clog2(N_REQ), width of the response ID.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot grant/accept.
- req_dividend  in  N_REQ*D_WIDTH  packed; slice i belongs to requester i.
- req_divisor  in  N_REQ*D_WIDTH  packed; slice i belongs to requester i.
- div_valid_in  out  1  divider start pulse.
- div_dividend  out  D_WIDTH  latched operand to the divider.
- div_divisor  out  D_WIDTH  latched operand to the divider.
- div_valid_out  in  1  divider done; level, held until cleared.
- div_quotient  in  D_WIDTH  divider result.
- div_clear  out  1  one-cycle pulse that returns the divider to idle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_quotient  out  D_WIDTH  result.
- rsp_err  out  1  set when the divide timed out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs and operand/result registers are 0.
  - last_grant = N_REQ-1, so the first grant goes to requester 0.
- IDLE:
  - The grant is the first asserted req_valid searching from last_grant+1 with wrap-around.
  - req_ready[g] is driven combinationally, one-hot, only in IDLE.
  - On grant: latch operands and the ID, set last_grant = g, go to ISSUE.
  - With no req_valid asserted, stay in IDLE.
- ISSUE: drive div_valid_in=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - div_dividend/div_divisor are held stable from ISSUE through CLEAR.
  - When div_valid_out=1: capture div_quotient, go to CLEAR.
  - A cycle counter runs in WAIT. When it reaches TIMEOUT: quotient=0, rsp_err=1, go to CLEAR.
- CLEAR: drive div_clear=1 for one cycle, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_quotient and rsp_err are held stable until rsp_ready=1.
  - Handshake cycle: go to IDLE and clear rsp_err.
- Latency:
  - Accept to rsp_valid = 3 + divider latency (ISSUE, CLEAR, plus one registered RESP entry).
  - Throughput is one request in flight; no acceptance happens during RESP.
- Boundary conditions:
  - div_valid_out is ignored outside WAIT.
  - If rsp_ready is already high when rsp_valid rises, the handshake completes that cycle; the next grant can occur on the following cycle at the earliest.
  - Requesters must hold valid and operands until their req_ready; a dropped req_valid is simply not granted.
  - A single requester asserting req_valid continuously is re-granted back-to-back.
  - Reset mid-operation aborts without a response. The divider is reset by the same reset net.

Optional Feature:
- Macro: DIVIDE_ARB_ZERO_BYPASS_EN.
- When defined:
  - A granted request with divisor==0 skips ISSUE/WAIT/CLEAR and goes IDLE -> RESP.
  - rsp_quotient = dividend>=0 ? {1'b0,{D_WIDTH-1{1'b1}}} : {1'b1,{D_WIDTH-1{1'b0}}}.
  - rsp_err=0.
  - div_valid_in is never pulsed for that request.
- When undefined: a zero divisor is sent to the divider like any other operand.

Decomposition:
- Package divide_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, CLEAR, RESP};
  - the SAT_POS/SAT_NEG constants as functions of D_WIDTH;
  - the ID width helper.
- One sub-module, rr_arbiter (N_REQ, last_grant in, req in, one-hot grant and index out), is purely combinational. State stays in the parent.

Test Plan:
- Bench divider model returns round((a<<10)/b) after 64 cycles.
- Requester 2 sends 30/4 -> one div_valid_in pulse; rsp_id=2, rsp_quotient=7680, rsp_err=0; div_clear pulses once, before rsp_valid.
- All four requesters valid from the same cycle, each with a distinct dividend -> rsp_id order 0,1,2,3 and each quotient matches its own operands.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_id/rsp_quotient stable; req_ready stays 0; no new div_valid_in.
- With DIVIDE_ARB_ZERO_BYPASS_EN, -5/0 -> rsp_quotient=32'h80000000 one cycle after accept, div_valid_in never asserted. Without the macro, the request goes through the divider.
- Model never returns done, TIMEOUT=100 -> rsp_err=1 and rsp_quotient=0 at cycle 100+3; div_clear pulses; the next request then completes normally.
- reset driven low in WAIT -> all outputs 0 immediately. After release, requesters 3 and 0 both valid -> requester 0 is granted first.
